// File: rtl/sram_pkg.sv
// sram_pkg
//   Types shared by the SRAM data-port arbiter and its response-ID FIFO.
//   obi_req_t : request fields muxed from the winning master to the slave.
//   obi_rsp_t : response fields demuxed back to the issuing master.
//   mst_id_e  : master identifier stored in the response-ID FIFO.
package sram_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

    typedef enum logic {
        MST_CORE = 1'b0,
        MST_DMA  = 1'b1
    } mst_id_e;

    function automatic mst_id_e mst_other(input mst_id_e m);
        return (m == MST_CORE) ? MST_DMA : MST_CORE;
    endfunction

endpackage

// File: rtl/sram_d_arbiter_rsp_id_fifo.sv
// rsp_id_fifo
//   In-order FIFO of master IDs, one entry per accepted-but-unanswered
//   request. Head entry names the master that owns the next response.
//   i_clk / i_rst : clock, asynchronous active-high reset (flushes FIFO)
//   i_push/i_din  : append an ID at the tail
//   i_pop         : drop the head entry
//   o_dout        : head ID (combinational read)
//   o_full/o_empty/o_count : occupancy status
//   Push and pop in one cycle are both honoured; the caller never pushes
//   into a full FIFO without popping in the same cycle.
module rsp_id_fifo
    import sram_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  mst_id_e       i_din,
    output mst_id_e       o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    mst_id_e       r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= MST_CORE;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (i_pop) r_rptr <= ptr_inc(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter
//   Two-master OBI arbiter in front of the SRAM data port.
//   M0 = core LSU, M1 = DMA/loader. Round-robin between the two onto one
//   OBI slave port; responses are routed back in order via a master-ID FIFO.
//   Zero added latency: grant and response are combinational pass-throughs.
// Ports
//   clk_i, rst_i                    : clock, asynchronous active-high reset
//   mX_req_i/addr/we/be/wdata       : master X request channel
//   mX_gnt_o                        : master X grant
//   mX_rvalid_o/mX_rdata_o          : master X response (rdata 0 when idle)
//   s_req_o/s_gnt_i/s_addr_o/...    : slave request channel
//   s_rvalid_i/s_rdata_i            : slave response channel
//   rsp_err_o                       : response seen with nothing outstanding
//   outstanding_o                   : requests accepted but not yet answered
module sram_d_arbiter
    import sram_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int RESET_PRIO      = 0,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_i,
    output logic          m0_gnt_o,
    input  logic [31:0]   m0_addr_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_be_i,
    input  logic [31:0]   m0_wdata_i,
    output logic          m0_rvalid_o,
    output logic [31:0]   m0_rdata_o,
    input  logic          m1_req_i,
    output logic          m1_gnt_o,
    input  logic [31:0]   m1_addr_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_be_i,
    input  logic [31:0]   m1_wdata_i,
    output logic          m1_rvalid_o,
    output logic [31:0]   m1_rdata_o,
    output logic          s_req_o,
    input  logic          s_gnt_i,
    output logic [31:0]   s_addr_o,
    output logic          s_we_o,
    output logic [3:0]    s_be_o,
    output logic [31:0]   s_wdata_o,
    input  logic          s_rvalid_i,
    input  logic [31:0]   s_rdata_i,
    output logic          rsp_err_o,
    output logic [OW-1:0] outstanding_o
);

    // The pointer records the last winner; after reset it names the master
    // that is NOT favoured, so RESET_PRIO wins the first contested cycle.
    localparam mst_id_e LP_RST_LAST = (RESET_PRIO == 0) ? MST_DMA : MST_CORE;

    mst_id_e  r_last_winner;
    mst_id_e  w_sel;
    mst_id_e  w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_can_issue;
    logic     w_s_req;
    logic     w_accept;
    logic     w_pop;
    obi_req_t w_m0;
    obi_req_t w_m1;
    obi_req_t w_s_fields;
    obi_rsp_t w_m0_rsp;
    obi_rsp_t w_m1_rsp;

    assign w_m0 = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign w_m1 = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

    always_comb begin
        w_sel = mst_other(r_last_winner);
        case ({m1_req_i, m0_req_i})
            2'b01:   w_sel = MST_CORE;
            2'b10:   w_sel = MST_DMA;
            default: w_sel = mst_other(r_last_winner);
        endcase
    end

    // A response popping this cycle frees the slot a new request needs.
    assign w_can_issue = !w_full || s_rvalid_i;
    assign w_s_req     = !rst_i && w_can_issue && (m0_req_i || m1_req_i);
    assign w_accept    = w_s_req && s_gnt_i;
    assign w_pop       = !rst_i && s_rvalid_i && !w_empty;

    always_comb begin
        w_s_fields = '0;
        if (!rst_i) w_s_fields = (w_sel == MST_DMA) ? w_m1 : w_m0;
    end

    assign s_req_o   = w_s_req;
    assign s_addr_o  = w_s_fields.addr;
    assign s_we_o    = w_s_fields.we;
    assign s_be_o    = w_s_fields.be;
    assign s_wdata_o = w_s_fields.wdata;

    assign m0_gnt_o = w_accept && (w_sel == MST_CORE);
    assign m1_gnt_o = w_accept && (w_sel == MST_DMA);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         r_last_winner <= LP_RST_LAST;
        else if (w_accept) r_last_winner <= w_sel;
    end

    rsp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_id_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_sel),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

    always_comb begin
        w_m0_rsp = '0;
        w_m1_rsp = '0;
        if (w_pop) begin
            if (w_head == MST_CORE) w_m0_rsp = '{rvalid: 1'b1, rdata: s_rdata_i};
            else                    w_m1_rsp = '{rvalid: 1'b1, rdata: s_rdata_i};
        end
    end

    assign m0_rvalid_o = w_m0_rsp.rvalid;
    assign m0_rdata_o  = w_m0_rsp.rdata;
    assign m1_rvalid_o = w_m1_rsp.rvalid;
    assign m1_rdata_o  = w_m1_rsp.rdata;

    assign rsp_err_o = !rst_i && s_rvalid_i && w_empty;

endmodule

// File: tb/tb_sram_d_arbiter.sv
// tb_sram_d_arbiter
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared with a queue-based reference of the arbiter rules;
//   the bench also plays the slave (accept queue plus word memory).
module tb_sram_d_arbiter;

    localparam int MAXO       = 2;
    localparam int RESET_PRIO = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        s_req, s_gnt, s_we, s_rvalid, rsp_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic [1:0]  outstanding;

    always #5 clk = ~clk;

    sram_d_arbiter #(.MAX_OUTSTANDING(MAXO), .RESET_PRIO(RESET_PRIO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
        .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .rsp_err_o(rsp_err), .outstanding_o(outstanding)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   q[$];             // master IDs in issue order
    int   last;             // last accepted master
    bit   e_acc, e_pop, e_g0, e_g1;
    int   e_sel;
    txn_t sq[$];            // slave-side accepted transactions
    logic [31:0] mem [logic [29:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    task automatic reset_model();
        q.delete();
        sq.delete();
        last  = 1 - RESET_PRIO;
        e_acc = 0; e_pop = 0; e_g0 = 0; e_g1 = 0;
    endtask

    task automatic check_model();
        int hs, head, sel;
        bit req;
        txn_t f;
        hs   = q.size();
        head = (hs > 0) ? q[0] : -1;
        if (rst) begin
            chk("rst_s_req", s_req, 0);   chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
            chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
            chk("rst_err", rsp_err, 0);   chk("rst_outst", outstanding, 0);
            chk("rst_s_addr", s_addr, 0);
            e_acc = 0; e_pop = 0; e_g0 = 0; e_g1 = 0;
            return;
        end
        req = (m0_req || m1_req) && (hs < MAXO || s_rvalid);
        if (m0_req && !m1_req)      sel = 0;
        else if (m1_req && !m0_req) sel = 1;
        else                        sel = 1 - last;
        e_sel = sel;
        e_acc = req && s_gnt;
        e_pop = s_rvalid && hs > 0;
        e_g0  = e_acc && sel == 0;
        e_g1  = e_acc && sel == 1;
        chk("s_req", s_req, req);
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("m0_rvalid", m0_rvalid, e_pop && head == 0);
        chk("m1_rvalid", m1_rvalid, e_pop && head == 1);
        chk("m0_rdata", m0_rdata, (e_pop && head == 0) ? s_rdata : 32'h0);
        chk("m1_rdata", m1_rdata, (e_pop && head == 1) ? s_rdata : 32'h0);
        chk("rsp_err", rsp_err, s_rvalid && hs == 0);
        chk("outstanding", outstanding, hs);
        if (req) begin
            f = (sel == 1) ? '{m1_addr, m1_we, m1_be, m1_wdata} : '{m0_addr, m0_we, m0_be, m0_wdata};
            chk("s_addr", s_addr, f.addr);
            chk("s_we", s_we, f.we);
            chk("s_be", s_be, f.be);
            chk("s_wdata", s_wdata, f.wdata);
        end
    endtask

    task automatic update_model();
        txn_t t;
        logic [31:0] w;
        if (rst) begin
            reset_model();
            return;
        end
        if (e_pop) begin
            void'(q.pop_front());
            if (sq.size() > 0) void'(sq.pop_front());
        end
        if (e_acc) begin
            q.push_back(e_sel);
            last = e_sel;
            t = (e_sel == 1) ? '{m1_addr, m1_we, m1_be, m1_wdata} : '{m0_addr, m0_we, m0_be, m0_wdata};
            sq.push_back(t);
            if (t.we) begin
                w = rd_mem(t.addr);
                for (int b = 0; b < 4; b++)
                    if (t.be[b]) w[b*8 +: 8] = t.wdata[b*8 +: 8];
                mem[t.addr[31:2]] = w;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic m_set(input int m, input bit r, input logic [31:0] a, input bit we,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin m0_req = r; m0_addr = a; m0_we = we; m0_be = be; m0_wdata = wd; end
        else        begin m1_req = r; m1_addr = a; m1_we = we; m1_be = be; m1_wdata = wd; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = 0;
        #1;
        reset_model();
        settle();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        m_set(0, 0, 0, 0, 0, 0);
        m_set(1, 0, 0, 0, 0, 0);
        do_reset();

        // 1: M0 read, granted same cycle, response next cycle
        mem[30'h2000_0001] = 32'hCAFE_0004;
        m_set(0, 1, 32'h8000_0004, 0, 4'hF, 0);
        s_gnt = 1;
        settle(); chk("t1_gnt", m0_gnt, 1); adv();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = rd_mem(32'h8000_0004);
        settle();
        chk("t1_rvalid", m0_rvalid, 1);
        chk("t1_rdata", m0_rdata, 32'hCAFE_0004);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        adv();
        s_rvalid = 0;

        // 2: both masters contend, M0 favoured after reset -> alternate
        do_reset();
        m_set(0, 1, 32'h8000_0010, 0, 4'hF, 0);
        m_set(1, 1, 32'h8000_0020, 0, 4'hF, 0);
        s_gnt = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin m0_req = 0; m1_req = 0; end
            s_rvalid = (i >= 1 && i <= 4);
            s_rdata  = 32'h1000_0000 + i;
            settle();
            if (i < 4) chk("t2_rr", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i >= 1 && i <= 4) chk("t2_route", {m1_rvalid, m0_rvalid}, (i % 2 == 1) ? 32'h1 : 32'h2);
            adv();
        end
        s_rvalid = 0;

        // 3: FIFO full stalls the third request until a response pops
        do_reset();
        m_set(0, 1, 32'h8000_0100, 0, 4'hF, 0);
        s_gnt = 1;
        for (int i = 0; i < 7; i++) begin
            s_rvalid = (i >= 3 && i <= 5);
            if (i == 4) m0_req = 0;
            settle();
            if (i == 2) begin chk("t3_stall_req", s_req, 0); chk("t3_stall_gnt", m0_gnt, 0); end
            if (i == 3) begin chk("t3_pop_req", s_req, 1); chk("t3_pop_gnt", m0_gnt, 1); end
            adv();
        end
        s_rvalid = 0;

        // 4: stray response with nothing outstanding
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t4_err", rsp_err, 1);
        chk("t4_rvalid", {m1_rvalid, m0_rvalid}, 0);
        adv();
        s_rvalid = 0;
        settle(); chk("t4_err_pulse", rsp_err, 0); chk("t4_outst", outstanding, 0); adv();

        // 5: M1 partial write then readback
        mem[30'h2000_0200] = 32'hAAAA_AAAA;
        m_set(1, 1, 32'h8000_0800, 1, 4'b0011, 32'h1234_5678);
        s_gnt = 1;
        settle();
        chk("t5_gnt", m1_gnt, 1);
        chk("t5_addr", s_addr, 32'h8000_0800);
        chk("t5_we", s_we, 1);
        chk("t5_be", s_be, 4'b0011);
        chk("t5_wdata", s_wdata, 32'h1234_5678);
        adv();
        m_set(1, 1, 32'h8000_0800, 0, 4'hF, 0);
        s_rvalid = 1; s_rdata = 0;
        settle(); chk("t5_wr_rvalid", m1_rvalid, 1); adv();
        m1_req = 0; s_gnt = 0; s_rdata = rd_mem(32'h8000_0800);
        settle();
        chk("t5_rd_rvalid", m1_rvalid, 1);
        chk("t5_rd_low", m1_rdata[15:0], 16'h5678);
        chk("t5_rd_word", m1_rdata, 32'hAAAA_5678);
        adv();
        s_rvalid = 0;

        // 6: asynchronous reset with one request outstanding
        m_set(0, 1, 32'h8000_0040, 0, 4'hF, 0);
        s_gnt = 1;
        settle(); adv();
        m0_req = 0; s_gnt = 0;
        settle(); chk("t6_outst_pre", outstanding, 1);
        #2;
        rst = 1;
        #1;
        chk("t6_outst_async", outstanding, 0);
        chk("t6_req_in_rst", s_req, 0);
        reset_model();
        adv();
        rst = 0;
        s_rvalid = 1; s_rdata = 32'h0BAD_0BAD;
        settle();
        chk("t6_stray_err", rsp_err, 1);
        chk("t6_stray_rvalid", {m1_rvalid, m0_rvalid}, 0);
        adv();
        s_rvalid = 0;

        // Randomized traffic: masters hold requests until granted
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!(m0_req && !e_g0))
                m_set(0, $urandom_range(0, 99) < 60, {2'b10, 25'($urandom), 5'h0} | 32'($urandom_range(0, 7) * 4),
                      1'($urandom), 4'($urandom), $urandom);
            if (!(m1_req && !e_g1))
                m_set(1, $urandom_range(0, 99) < 60, {2'b10, 25'($urandom), 5'h0} | 32'($urandom_range(0, 7) * 4),
                      1'($urandom), 4'($urandom), $urandom);
            s_gnt = $urandom_range(0, 99) < 70;
            if (sq.size() > 0) begin
                s_rvalid = $urandom_range(0, 99) < 50;
                s_rdata  = sq[0].we ? 32'h0 : rd_mem(sq[0].addr);
            end else begin
                s_rvalid = $urandom_range(0, 99) < 5;
                s_rdata  = $urandom;
            end
            settle();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
